window_gen_3x3: RTL and testbench

Reader end of the line-buffer chain. Consumes the raster pixel stream (one pixel per enabled cycle) through two internal IMG_W-deep line delays and a 3x3 shift-register array, and emits complete 3x3 windows to the convolution MAC stage. Only fully-interior windows are emitted; there is no border padding. The block tracks row and column position and flags end of frame.

---
 rtl/window_gen_3x3_if.sv | 28 ++
 rtl/window_gen_3x3.sv | 101 ++++++++++
 tb/tb_window_gen_3x3.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle between the line-buffer reader and the MAC stage.
// Handshake: en is a valid strobe with no ready; a pixel is taken on every rising clk with en=1.
interface window_gen_3x3_if #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int DW    = 8
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic            en;
    logic [DW-1:0]   pixel_in;
    logic [9*DW-1:0] window;
    logic            win_valid;
    logic            frame_done;
    logic [RW-1:0]   row_cnt;
    logic [CW-1:0]   col_cnt;

    modport master (
        output en, pixel_in,
        input  window, win_valid, frame_done, row_cnt, col_cnt
    );

    modport slave (
        input  en, pixel_in,
        output window, win_valid, frame_done, row_cnt, col_cnt
    );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 window generator: two IMG_W-deep line delays feed a 3x3 tap array; only
// fully-interior windows are registered out, one cycle after the completing pixel.
module window_gen_3x3 #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int DW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    window_gen_3x3_if.slave    bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [DW-1:0]   line1_q [IMG_W];
    logic [DW-1:0]   line1_d [IMG_W];
    logic [DW-1:0]   line2_q [IMG_W];
    logic [DW-1:0]   line2_d [IMG_W];
    logic [DW-1:0]   taps_q  [9];
    logic [DW-1:0]   taps_d  [9];
    logic [9*DW-1:0] window_q, window_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;

    always_comb begin
        line1_d      = line1_q;
        line2_d      = line2_q;
        taps_d       = taps_q;
        window_d     = window_q;
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (bus.en) begin
            line1_d[0] = bus.pixel_in;
            line2_d[0] = line1_q[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                line1_d[k] = line1_q[k-1];
                line2_d[k] = line2_q[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                taps_d[3*i]   = taps_q[3*i+1];
                taps_d[3*i+1] = taps_q[3*i+2];
            end
            // Oldest line on top, newest pixel bottom-right.
            taps_d[2] = line2_q[IMG_W-1];
            taps_d[5] = line1_q[IMG_W-1];
            taps_d[8] = bus.pixel_in;

            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // Row gating also keeps stale line-delay contents from a prior frame out.
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                win_valid_d  = 1'b1;
                frame_done_d = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
                for (int k = 0; k < 9; k++) begin
                    window_d[DW*k +: DW] = taps_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < IMG_W; k++) begin
                line1_q[k] <= '0;
                line2_q[k] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                taps_q[k] <= '0;
            end
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            line1_q      <= line1_d;
            line2_q      <= line2_d;
            taps_q       <= taps_d;
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    assign bus.window     = window_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.row_cnt    = row_q;
    assign bus.col_cnt    = col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 instance and a 5x3 instance, each checked every
// cycle against an image-array model, plus literal window lists for directed frames.
module tb_window_gen_3x3;
  localparam int DW = 8;
  localparam int WW = 9 * DW;

  logic clk = 1'b0;
  logic rst;
  logic started = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_gen_3x3_if #(.IMG_W(4), .IMG_H(4), .DW(DW)) bus_a ();
  window_gen_3x3_if #(.IMG_W(5), .IMG_H(3), .DW(DW)) bus_b ();

  window_gen_3x3 #(.IMG_W(4), .IMG_H(4), .DW(DW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  window_gen_3x3 #(.IMG_W(5), .IMG_H(3), .DW(DW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic          en_v [2];
  logic [DW-1:0] px_v [2];
  assign bus_a.en       = en_v[0];
  assign bus_a.pixel_in = px_v[0];
  assign bus_b.en       = en_v[1];
  assign bus_b.pixel_in = px_v[1];

  logic [WW-1:0] d_win [2];
  logic          d_val [2];
  logic          d_fd  [2];
  int            d_row [2];
  int            d_col [2];
  assign d_win[0] = bus_a.window;
  assign d_win[1] = bus_b.window;
  assign d_val[0] = bus_a.win_valid;
  assign d_val[1] = bus_b.win_valid;
  assign d_fd[0]  = bus_a.frame_done;
  assign d_fd[1]  = bus_b.frame_done;
  assign d_row[0] = int'(bus_a.row_cnt);
  assign d_row[1] = int'(bus_b.row_cnt);
  assign d_col[0] = int'(bus_a.col_cnt);
  assign d_col[1] = int'(bus_b.col_cnt);

  // Behavioural model: the current frame is written into an image array and a
  // window is cut out of it at (r-2..r, c-2..c) whenever r>=2 and c>=2.
  int            img_w [2] = '{4, 5};
  int            img_h [2] = '{4, 3};
  logic [DW-1:0] img   [2][5][5];
  int            m_row [2];
  int            m_col [2];
  logic          m_val [2];
  logic          m_fd  [2];
  logic [WW-1:0] m_win [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_row[u] = 0;
        m_col[u] = 0;
        m_val[u] = 1'b0;
        m_fd[u]  = 1'b0;
        m_win[u] = '0;
      end else if (en_v[u]) begin
        img[u][m_row[u]][m_col[u]] = px_v[u];
        if (m_row[u] >= 2 && m_col[u] >= 2) begin
          m_val[u] = 1'b1;
          m_fd[u]  = (m_row[u] == img_h[u] - 1) && (m_col[u] == img_w[u] - 1);
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              m_win[u][DW*(3*i+j) +: DW] = img[u][m_row[u]-2+i][m_col[u]-2+j];
        end else begin
          m_val[u] = 1'b0;
          m_fd[u]  = 1'b0;
        end
        m_col[u]++;
        if (m_col[u] == img_w[u]) begin
          m_col[u] = 0;
          m_row[u]++;
          if (m_row[u] == img_h[u]) m_row[u] = 0;
        end
      end else begin
        m_val[u] = 1'b0;
        m_fd[u]  = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [WW-1:0] got_q0 [$];
  logic [WW-1:0] got_q1 [$];
  logic          fd_q0  [$];
  logic          fd_q1  [$];
  logic [WW-1:0] exp_q  [$];

  // Per-cycle compare against the model, plus capture of emitted windows.
  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d_win_valid", u), WW'(d_val[u]), WW'(m_val[u]));
        chk($sformatf("u%0d_frame_done", u), WW'(d_fd[u]), WW'(m_fd[u]));
        chk($sformatf("u%0d_row_cnt", u), WW'(d_row[u]), WW'(m_row[u]));
        chk($sformatf("u%0d_col_cnt", u), WW'(d_col[u]), WW'(m_col[u]));
        chk($sformatf("u%0d_window", u), d_win[u], m_win[u]);
      end
      if (d_val[0] === 1'b1) begin
        got_q0.push_back(d_win[0]);
        fd_q0.push_back(d_fd[0]);
      end
      if (d_val[1] === 1'b1) begin
        got_q1.push_back(d_win[1]);
        fd_q1.push_back(d_fd[1]);
      end
    end
  end

  function automatic logic [WW-1:0] pack9(input int a, b, c, d, e, f, g, h, i);
    int t [9];
    logic [WW-1:0] r;
    t = '{a, b, c, d, e, f, g, h, i};
    r = '0;
    for (int k = 0; k < 9; k++) r[DW*k +: DW] = t[k][DW-1:0];
    return r;
  endfunction

  task automatic drive(input int u, input int p);
    @(negedge clk);
    en_v[u] = 1'b1;
    px_v[u] = p[DW-1:0];
  endtask

  task automatic idle();
    @(negedge clk);
    en_v[0] = 1'b0;
    en_v[1] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en_v[0] = 1'b0;
    en_v[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    got_q0.delete();
    got_q1.delete();
    fd_q0.delete();
    fd_q1.delete();
    exp_q.delete();
  endtask

  // Literal windows for pixels 1..16 on a 4x4 image.
  task automatic check_std(input string tag);
    exp_q.push_back(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    exp_q.push_back(pack9(2, 3, 4, 6, 7, 8, 10, 11, 12));
    exp_q.push_back(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    exp_q.push_back(pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    chk({tag, "_count"}, WW'(got_q0.size()), WW'(4));
    for (int k = 0; k < 4 && k < got_q0.size(); k++) begin
      chk($sformatf("%s_win%0d", tag, k), got_q0[k], exp_q[k]);
      chk($sformatf("%s_fd%0d", tag, k), WW'(fd_q0[k]), WW'(k == 3));
    end
    clear_logs();
  endtask

  initial begin
    rst = 1'b1;
    en_v = '{1'b0, 1'b0};
    px_v = '{'0, '0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_window", d_win[0], '0);
    chk("reset_row", WW'(d_row[0]), WW'(0));
    clear_logs();

    // Continuous frame.
    for (int p = 1; p <= 16; p++) drive(0, p);
    idle();
    idle();
    check_std("s1");

    // en low on every other cycle.
    for (int p = 1; p <= 16; p++) begin
      drive(0, p);
      idle();
    end
    idle();
    check_std("s2");

    // Two frames back to back.
    for (int p = 1; p <= 16; p++) drive(0, p);
    for (int p = 101; p <= 116; p++) drive(0, p);
    idle();
    idle();
    exp_q.push_back(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    exp_q.push_back(pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    exp_q.push_back(pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));
    exp_q.push_back(pack9(106, 107, 108, 110, 111, 112, 114, 115, 116));
    chk("s3_count", WW'(got_q0.size()), WW'(8));
    if (got_q0.size() == 8) begin
      chk("s3_f1_first", got_q0[0], exp_q[0]);
      chk("s3_f1_last", got_q0[3], exp_q[1]);
      chk("s3_f2_first", got_q0[4], exp_q[2]);
      chk("s3_f2_last", got_q0[7], exp_q[3]);
      chk("s3_f2_fd", WW'(fd_q0[7]), WW'(1));
    end
    clear_logs();

    // Reset mid-frame after pixel 7.
    for (int p = 1; p <= 7; p++) drive(0, p);
    idle();
    chk("s4_row_before", WW'(d_row[0]), WW'(1));
    chk("s4_col_before", WW'(d_col[0]), WW'(3));
    do_reset();
    chk("s4_rst_window", d_win[0], '0);
    chk("s4_rst_valid", WW'(d_val[0]), WW'(0));
    chk("s4_rst_row", WW'(d_row[0]), WW'(0));
    chk("s4_rst_col", WW'(d_col[0]), WW'(0));
    clear_logs();
    for (int p = 1; p <= 16; p++) drive(0, p);
    idle();
    idle();
    check_std("s4");

    // 5x3 instance, pixels 1..15.
    for (int p = 1; p <= 15; p++) drive(1, p);
    idle();
    idle();
    exp_q.push_back(pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    exp_q.push_back(pack9(3, 4, 5, 8, 9, 10, 13, 14, 15));
    chk("s5_count", WW'(got_q1.size()), WW'(3));
    if (got_q1.size() == 3) begin
      chk("s5_first", got_q1[0], exp_q[0]);
      chk("s5_last", got_q1[2], exp_q[1]);
      chk("s5_fd_first", WW'(fd_q1[0]), WW'(0));
      chk("s5_fd_last", WW'(fd_q1[2]), WW'(1));
    end
    clear_logs();

    // Random enables and pixels on both instances.
    repeat (400) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        en_v[u] = 1'($urandom_range(0, 1));
        px_v[u] = DW'($urandom_range(0, 255));
      end
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
